// File: rtl/transceiver_sched.sv
// Round-robin scheduler sharing one serial transceiver among NUM_REQ byte requesters.
// Bytes go out LSB-first on tx_data/tx_en, then the decoded byte (or a timeout) comes back as a tagged response.
module transceiver_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_en,
  output logic                 tx_data,
  input  logic                 rx_done,
  input  logic [7:0]           rx_byte,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_match,
  output logic                 rsp_timeout
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      byte_q, byte_d;
  logic [2:0]      bit_q, bit_d;
  logic [15:0]     wait_q, wait_d;
  logic            tx_en_q, tx_en_d;
  logic            tx_data_q, tx_data_d;
  logic            busy_q, busy_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_match_q, rsp_match_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  logic [7:0]      req_bytes [NUM_REQ];
  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[8*gi +: 8];
  end

  // Scan upward from the requester after the last grant, wrapping around.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Gated by rst so the grant vanishes the moment reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst && state_q == IDLE && gnt_found) req_ready = NUM_REQ'(1) << gnt_id;
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    id_d          = id_q;
    byte_d        = byte_q;
    bit_d         = bit_q;
    wait_d        = wait_q;
    tx_en_d       = tx_en_q;
    tx_data_d     = tx_data_q;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_match_d   = rsp_match_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: if (gnt_found) begin
        state_d   = SHIFT;
        id_d      = gnt_id;
        last_d    = gnt_id;
        byte_d    = req_bytes[gnt_id];
        bit_d     = 3'd0;
        tx_en_d   = 1'b1;
        tx_data_d = req_bytes[gnt_id][0];
      end
      SHIFT: if (bit_q == 3'd7) begin
        state_d   = WAIT;
        tx_en_d   = 1'b0;
        tx_data_d = 1'b0;
        wait_d    = '0;
      end else begin
        bit_d     = bit_q + 3'd1;
        tx_data_d = byte_q[bit_q + 3'd1];
      end
      WAIT: begin
        // A done on the final cycle takes precedence over the timeout.
        if (rx_done) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = id_q;
          rsp_data_d    = rx_byte;
          rsp_match_d   = (rx_byte == byte_q);
          rsp_timeout_d = 1'b0;
        end else if (wait_q == 16'(TIMEOUT - 1)) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = id_q;
          rsp_data_d    = 8'h00;
          rsp_match_d   = 1'b0;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_q        <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      byte_q        <= '0;
      bit_q         <= '0;
      wait_q        <= '0;
      tx_en_q       <= 1'b0;
      tx_data_q     <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_match_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      id_q          <= id_d;
      byte_q        <= byte_d;
      bit_q         <= bit_d;
      wait_q        <= wait_d;
      tx_en_q       <= tx_en_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_match_q   <= rsp_match_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_match   = rsp_match_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_transceiver_sched.sv
// Bench for transceiver_sched: a transceiver model answers each frame, a scoreboard holds expected responses.
module tb_transceiver_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_en, tx_data;
  logic                 rx_done = 1'b0;
  logic [7:0]           rx_byte = 8'h00;
  logic                 busy, rsp_valid, rsp_match, rsp_timeout;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_data;

  transceiver_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_en(tx_en), .tx_data(tx_data), .rx_done(rx_done), .rx_byte(rx_byte), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_match(rsp_match),
    .rsp_timeout(rsp_timeout)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       match;
    logic       to;
    int         lat;
    int         gcyc;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  exp_t sb[$];
  int gnt_log[$];
  int gnt_cyc_log[$];
  int rsp_cyc_log[$];
  int n_grants = 0;
  int phase = 0;
  int exp_last = NUM_REQ - 1;

  // Per-requester transceiver behaviour: WAIT cycles before done (0 = never), rx corruption, stale pulse.
  int         cfg_wait [NUM_REQ] = '{3, 3, 3, 3};
  logic [7:0] cfg_xor  [NUM_REQ] = '{8'h00, 8'h00, 8'h00, 8'h00};
  bit         cfg_stale[NUM_REQ] = '{0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] rr_model(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last + k) % NUM_REQ;
      if (v[idx]) return NUM_REQ'(1) << idx;
    end
    return '0;
  endfunction

  // Monitor, scoreboard and transceiver model, all evaluated on the falling edge.
  initial begin
    int cur_id, cur_wait, nbits, wcnt, gid;
    logic [7:0] cur_tx, cur_xor, bits, hold_data;
    bit cur_stale, hold_pending;
    exp_t e;
    cur_id = 0; cur_wait = 0; nbits = 0; wcnt = 0; gid = 0;
    cur_tx = '0; cur_xor = '0; bits = '0; hold_data = '0;
    cur_stale = 0; hold_pending = 0;
    forever begin
      @(negedge clk);
      rx_done = 1'b0;
      rx_byte = 8'h00;
      if (!rst) begin
        phase = 0; sb.delete(); exp_last = NUM_REQ - 1; hold_pending = 0;
        continue;
      end
      check("busy", busy, phase != 0);
      check("tx_en", tx_en, phase == 1);
      check("req_ready", req_ready, (phase == 0) ? rr_model(exp_last, req_valid) : '0);
      if (hold_pending && !rsp_valid) begin
        check("rsp_hold", rsp_data, hold_data);
        hold_pending = 0;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_match", rsp_match, e.match);
          check("rsp_timeout", rsp_timeout, e.to);
          check("latency", cyc - e.gcyc, e.lat);
          $display("rsp id=%0d data=%02h match=%0b timeout=%0b latency=%0d", rsp_id, rsp_data,
                   rsp_match, rsp_timeout, cyc - e.gcyc);
        end
        rsp_cyc_log.push_back(cyc);
        hold_pending = 1;
        hold_data = rsp_data;
        phase = 0;
      end else if (|(req_valid & req_ready)) begin
        for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_ready[i]) gid = i;
        cur_id = gid;
        cur_tx = req_data[8*gid +: 8];
        cur_wait = cfg_wait[gid];
        cur_xor = cfg_xor[gid];
        cur_stale = cfg_stale[gid];
        e.id = gid;
        if (cur_wait >= 1 && cur_wait <= TIMEOUT) begin
          e.data = cur_tx ^ cur_xor; e.match = (cur_xor == 8'h00); e.to = 1'b0; e.lat = 9 + cur_wait;
        end else begin
          e.data = 8'h00; e.match = 1'b0; e.to = 1'b1; e.lat = 9 + TIMEOUT;
        end
        e.gcyc = cyc;
        sb.push_back(e);
        gnt_log.push_back(gid);
        gnt_cyc_log.push_back(cyc);
        n_grants++;
        exp_last = gid;
        phase = 1; nbits = 0; wcnt = 0; bits = '0;
      end else if (phase == 1) begin
        bits[nbits] = tx_data;
        nbits++;
        if (cur_stale && nbits == 3) begin
          rx_done = 1'b1;
          rx_byte = 8'hFF;
        end
        if (nbits == 8) begin
          check("tx_byte", bits, cur_tx);
          phase = 2;
        end
      end else if (phase == 2) begin
        check("tx_data_idle", tx_data, 0);
        wcnt++;
        if (cur_wait != 0 && wcnt == cur_wait) begin
          rx_done = 1'b1;
          rx_byte = cur_tx ^ cur_xor;
        end
        if (wcnt > TIMEOUT + 3) begin
          check("rsp_missing", 0, 1);
          if (sb.size() != 0) void'(sb.pop_front());
          phase = 0;
        end
      end
    end
  end

  task automatic wait_grants(input int target);
    int t;
    t = 0;
    while (n_grants < target && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    if (n_grants < target) check("grant_wait", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || phase != 0) && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 500) check("idle_wait", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int b, r, nr;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r, nr;
    // Reset state, with requests pending to prove req_ready is held low.
    req_valid = '1;
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_match", rsp_match, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    req_valid = '0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single request, 20 WAIT cycles: latency 29.
    cfg_wait[2] = 20;
    req_data[8*2 +: 8] = 8'hA5;
    req_valid = 4'b0100;
    b = gnt_log.size();
    wait_grants(n_grants + 1);
    req_valid = '0;
    wait_idle();
    check("single_id", gnt_log[b], 2);

    // Round robin from reset with all requesters active.
    apply_reset();
    cfg_wait = '{3, 3, 3, 3};
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    b = gnt_log.size();
    wait_grants(n_grants + 5);
    req_valid = '0;
    wait_idle();
    for (int k = 0; k < 5; k++) check("rr_order", gnt_log[b + k], k % NUM_REQ);

    // Timeout on requester 1, then requester 2 granted in the very next IDLE cycle.
    cfg_wait[1] = 0;
    cfg_wait[2] = 4;
    req_data = {8'h00, 8'h5A, 8'hC3, 8'h00};
    req_valid = 4'b0110;
    b = gnt_log.size();
    r = rsp_cyc_log.size();
    wait_grants(n_grants + 2);
    req_valid = '0;
    wait_idle();
    check("to_first_id", gnt_log[b], 1);
    check("to_second_id", gnt_log[b + 1], 2);
    check("b2b_gap", gnt_cyc_log[b + 1] - rsp_cyc_log[r], 1);

    // Mismatch with a stale done pulse during SHIFT.
    cfg_wait[3] = 6;
    cfg_xor[3] = 8'h01;
    cfg_stale[3] = 1;
    req_data[8*3 +: 8] = 8'h3C;
    req_valid = 4'b1000;
    r = rsp_cyc_log.size();
    wait_grants(n_grants + 1);
    req_valid = '0;
    wait_idle();
    check("mismatch_rsp_count", rsp_cyc_log.size() - r, 1);
    cfg_xor[3] = 8'h00;
    cfg_stale[3] = 0;

    // Done on the final WAIT cycle beats the timeout; one cycle earlier too.
    cfg_wait[0] = TIMEOUT;
    cfg_wait[1] = TIMEOUT - 1;
    req_data = {8'h00, 8'h00, 8'h96, 8'h69};
    req_valid = 4'b0011;
    wait_grants(n_grants + 2);
    req_valid = '0;
    wait_idle();

    // Reset in the middle of SHIFT.
    cfg_wait[1] = 5;
    req_valid = 4'b0010;
    wait_grants(n_grants + 1);
    req_valid = 4'b1111;
    repeat (4) @(posedge clk);
    #2;
    nr = rsp_cyc_log.size();
    rst = 1'b0;
    #1;
    check("midrst_tx_en", tx_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 0);
    repeat (3) @(posedge clk);
    check("midrst_no_rsp", rsp_cyc_log.size(), nr);
    #1 rst = 1'b1;
    b = gnt_log.size();
    wait_grants(n_grants + 1);
    req_valid = '0;
    wait_idle();
    check("post_rst_winner", gnt_log[b], 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
